float_minmax_reduce: RTL and testbench
======================================

# float_minmax_reduce

Streaming min/max reducer for the 1-sign/EXPONENT/MANTISSA float format used throughout the shader datapath. It accepts one float per cycle over a valid/ready stream delimited by a last flag, and tracks the running minimum and maximum with their stream indices. It returns one result beat per stream. Typical uses are bounding-box extents and depth-range reduction ahead of the rasteriser.

## Interface
- EXPONENT, 6, exponent field width
- MANTISSA, 11, mantissa field width
- IDX_W, 8, index width; streams up to 2^IDX_W elements are indexed exactly
- W (local), EXPONENT+MANTISSA+1, word width; bit W-1 is the sign, the lower bits are the magnitude
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  W  float operand
- in_last  in  1  final beat of the stream
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_min  out  W  minimum value, exactly as received
- out_max  out  W  maximum value, exactly as received
- out_min_idx  out  IDX_W  index of the first occurrence of the minimum
- out_max_idx  out  IDX_W  index of the first occurrence of the maximum
- out_count  out  IDX_W+1  number of elements in the stream, saturating
- out_overflow  out  1  stream exceeded 2^IDX_W elements

## Operation
- **Ordering key.** Each value maps to an unsigned key of width W.
  - Magnitude zero: key = {1, 0...0}. This makes +0 and −0 equal.
  - Sign 0: key = {1, mag}.
  - Sign 1: key = {0, ~mag}.
- **Comparisons are strict on the key.** Equal values never replace an incumbent, so ties keep the earliest index. Equal negatives are equal, not greater.
- **No special values.** There is no NaN or Inf handling. An all-ones exponent is an ordinary large magnitude.
- **States:** ACCUM and HOLD.
- **ACCUM (reset state).** in_ready = 1, out_valid = 0. A beat is accepted when in_valid && in_ready.
  - First beat (count == 0): load min = max = in_data; min_idx = max_idx = 0; count = 1.
  - Later beats: if key(in_data) < key(min), load min and set min_idx = cur_idx. If key(in_data) > key(max), load max and set max_idx = cur_idx. Both checks are evaluated in the same cycle.
  - cur_idx = min(count, 2^IDX_W − 1).
  - count increments and saturates at 2^IDX_W. out_overflow sets when a beat is accepted while count == 2^IDX_W.
  - An accepted beat with in_last = 1 moves the block to HOLD. This includes a single-beat stream.
- **HOLD.** in_ready = 0, out_valid = 1. All outputs are stable until out_valid && out_ready.
  - On that handshake, clear count and overflow and return to ACCUM.
  - The min/max/idx registers keep their stale values. They are overwritten by the next first beat.
- **Outputs.** Every output except in_ready comes directly from a register. in_ready is decoded from the state only, never from out_ready.
- **Reset.** Asserting reset at any time, including mid-stream or in HOLD, returns the block to ACCUM immediately.
  - All registered outputs are cleared: out_min, out_max, both idx, out_count, out_overflow, out_valid = 0.
  - in_ready = 1 once reset deasserts.
  - A partial stream is discarded.

## Timing
- Throughput is 1 beat per cycle within a stream.
- Latency: out_valid rises on the edge that accepts the in_last beat and is visible the following cycle.
- There is at least one dead input cycle per stream (the HOLD cycle). Back-to-back streams run at N+1 cycles per N-beat stream when out_ready is held high.
- While in HOLD, in_valid is ignored and the producer must hold its beat.
- The first beat of the next stream can be accepted in the cycle after the out handshake.
- The critical path is two W-bit magnitude compares plus a register-enable mux. There are no internal pipeline stages.

## Test plan
Values use EXPONENT=6, MANTISSA=11, bias 31: +1.0 = 0x0F800, +2.0 = 0x10000, −1.0 = 0x2F800, −2.0 = 0x30000, +0 = 0x00000, −0 = 0x20000.

- **Mixed signs.** Stream +1.0, −2.0, +2.0, −1.0 (last), out_ready = 1 → one cycle after the last beat: out_min = 0x30000, min_idx = 1, out_max = 0x10000, max_idx = 2, out_count = 4, out_overflow = 0.
- **Ties and zeros.** Stream −0, +0 (last) → min = max = 0x20000, both idx 0. Stream −1.0, −1.0 (last) → min = max = 0x2F800, both idx 0.
- **Backpressure.** Single-beat stream +2.0 (last), then out_ready low for 5 cycles with in_valid high →
  - out_valid stays high and in_ready stays 0 for all 5 cycles; outputs are stable; out_count = 1.
  - After the handshake, the next beat is accepted in the following cycle.
- **Overflow (IDX_W = 2).** Stream +0, +0, +0, +0, +2.0 (last) → out_count = 4, out_overflow = 1, max = 0x10000, max_idx = 3, min_idx = 0.
- **Async reset.** Assert reset asynchronously after 2 beats of a stream → all outputs 0 without waiting for a clock edge.
  - After deassert, in_ready = 1.
  - A fresh stream −1.0 (last) returns min = max = 0x2F800, count = 1.
- **Throughput.** Three 4-beat streams with in_valid and out_ready held high → exactly 15 cycles from the first accept to the third result handshake.

Source files
------------

// File: rtl/float_minmax_reduce.sv
// float_minmax_reduce
//   Streaming min/max reducer for sign/exponent/mantissa floats. One float per
//   cycle is accepted over a valid/ready stream closed by a last flag. It tracks
//   the running minimum and maximum and the index of the first occurrence of
//   each. It then presents one result beat per stream.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_data is the operand, in_last ends the stream
//   out_valid/out_ready   result handshake
//   out_min/out_max       extreme values, bit-exact as received
//   out_min_idx/_max_idx  stream index of the first occurrence of each extreme
//   out_count             elements seen, saturating at 2^IDX_W
//   out_overflow          stream carried more than 2^IDX_W elements
module float_minmax_reduce #(
   parameter int EXPONENT = 6,
   parameter int MANTISSA = 11,
   parameter int IDX_W    = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [EXPONENT+MANTISSA:0]          in_data,
   input  logic                                in_last,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [EXPONENT+MANTISSA:0]          out_min,
   output logic [EXPONENT+MANTISSA:0]          out_max,
   output logic [IDX_W-1:0]                    out_min_idx,
   output logic [IDX_W-1:0]                    out_max_idx,
   output logic [IDX_W:0]                      out_count,
   output logic                                out_overflow
);

   localparam int W = EXPONENT + MANTISSA + 1;

   localparam logic [IDX_W:0]   CNT_MAX  = {1'b1, {IDX_W{1'b0}}};
   localparam logic [IDX_W:0]   CNT_ZERO = {(IDX_W+1){1'b0}};
   localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_MAX  = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Map a float to an unsigned key whose integer order is the numeric order.
   // Both zeros share one key, so +0 and -0 compare equal.
   function automatic logic [W-1:0] order_key(input logic [W-1:0] v);
      logic [W-2:0] mag;
      mag = v[W-2:0];
      if (mag == {(W-1){1'b0}}) begin
         order_key = {1'b1, {(W-1){1'b0}}};
      end else if (v[W-1] == 1'b0) begin
         order_key = {1'b1, mag};
      end else begin
         order_key = {1'b0, ~mag};
      end
   endfunction

   state_t           state_q, state_d;
   logic [W-1:0]     min_q, min_d;
   logic [W-1:0]     max_q, max_d;
   logic [IDX_W-1:0] min_idx_q, min_idx_d;
   logic [IDX_W-1:0] max_idx_q, max_idx_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic             accept_s;
   logic [IDX_W-1:0] cur_idx_s;
   logic [W-1:0]     in_key_s;
   logic [W-1:0]     min_key_s;
   logic [W-1:0]     max_key_s;

   // Next-state logic: accumulate extremes in ACCUM, present the result in HOLD.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      max_d     = max_q;
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;

      accept_s  = in_valid && (state_q == ACCUM);
      // Indices past the representable range pin to the top index.
      cur_idx_s = (count_q >= {1'b0, IDX_MAX}) ? IDX_MAX : count_q[IDX_W-1:0];
      in_key_s  = order_key(in_data);
      min_key_s = order_key(min_q);
      max_key_s = order_key(max_q);

      case (state_q)
         ACCUM: begin
            if (accept_s) begin
               if (count_q == CNT_ZERO) begin
                  min_d     = in_data;
                  max_d     = in_data;
                  min_idx_d = IDX_ZERO;
                  max_idx_d = IDX_ZERO;
               end else begin
                  // Strict compares: a tie keeps the earlier incumbent.
                  if (in_key_s < min_key_s) begin
                     min_d     = in_data;
                     min_idx_d = cur_idx_s;
                  end else begin
                     min_d     = min_q;
                  end
                  if (in_key_s > max_key_s) begin
                     max_d     = in_data;
                     max_idx_d = cur_idx_s;
                  end else begin
                     max_d     = max_q;
                  end
               end
               if (count_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + CNT_ONE;
               end
               if (in_last) begin
                  state_d = HOLD;
                  valid_d = 1'b1;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               // Extremes stay stale; the next first beat overwrites them.
               state_d = ACCUM;
               valid_d = 1'b0;
               count_d = CNT_ZERO;
               ovf_d   = 1'b0;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = ACCUM;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and result registers; reset clears everything and discards a partial stream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ACCUM;
         min_q     <= {W{1'b0}};
         max_q     <= {W{1'b0}};
         min_idx_q <= IDX_ZERO;
         max_idx_q <= IDX_ZERO;
         count_q   <= CNT_ZERO;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         max_q     <= max_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
      end
   end

   // in_ready depends only on state so it never combinationally follows out_ready.
   assign in_ready     = (state_q == ACCUM);
   assign out_valid    = valid_q;
   assign out_min      = min_q;
   assign out_max      = max_q;
   assign out_min_idx  = min_idx_q;
   assign out_max_idx  = max_idx_q;
   assign out_count    = count_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_float_minmax_reduce.sv
// Directed bench for float_minmax_reduce: a default instance (IDX_W=8) and a
// small-index instance (IDX_W=2) for the saturation/overflow case.
module tb_float_minmax_reduce;

   localparam logic [17:0] P1 = 18'h0F800;
   localparam logic [17:0] P2 = 18'h10000;
   localparam logic [17:0] N1 = 18'h2F800;
   localparam logic [17:0] N2 = 18'h30000;
   localparam logic [17:0] PZ = 18'h00000;
   localparam logic [17:0] NZ = 18'h20000;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
   logic [17:0] in_data, out_min, out_max;
   logic [7:0]  out_min_idx, out_max_idx;
   logic [8:0]  out_count;

   logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_overflow2;
   logic [17:0] in_data2, out_min2, out_max2;
   logic [1:0]  out_min_idx2, out_max_idx2;
   logic [2:0]  out_count2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   float_minmax_reduce #(.EXPONENT(6), .MANTISSA(11), .IDX_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_min(out_min), .out_max(out_max),
      .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
      .out_count(out_count), .out_overflow(out_overflow)
   );

   float_minmax_reduce #(.EXPONENT(6), .MANTISSA(11), .IDX_W(2)) dut2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_min(out_min2), .out_max(out_max2),
      .out_min_idx(out_min_idx2), .out_max_idx(out_max_idx2),
      .out_count(out_count2), .out_overflow(out_overflow2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [17:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send2(input logic [17:0] d, input logic last);
      in_valid2 = 1'b1;
      in_data2  = d;
      in_last2  = last;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      in_last2  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [17:0] tp_data [4];
   int          beat, hs_cnt, first_acc, last_hs;
   logic        acc, hs;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_data = 18'h0; in_last = 1'b0; out_ready = 1'b1;
      in_valid2 = 1'b0; in_data2 = 18'h0; in_last2 = 1'b0; out_ready2 = 1'b1;
      tp_data[0] = P1; tp_data[1] = N2; tp_data[2] = P2; tp_data[3] = N1;

      // Reset state
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_min",   32'(out_min),   32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_ovf",   32'(out_overflow), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      step();
      chk("rst_ready", 32'(in_ready), 32'd1);

      // Mixed signs
      send(P1, 1'b0); send(N2, 1'b0); send(P2, 1'b0); send(N1, 1'b1);
      chk("mix_valid",   32'(out_valid),   32'd1);
      chk("mix_ready",   32'(in_ready),    32'd0);
      chk("mix_min",     32'(out_min),     32'h30000);
      chk("mix_min_idx", 32'(out_min_idx), 32'd1);
      chk("mix_max",     32'(out_max),     32'h10000);
      chk("mix_max_idx", 32'(out_max_idx), 32'd2);
      chk("mix_count",   32'(out_count),   32'd4);
      chk("mix_ovf",     32'(out_overflow), 32'd0);
      step();
      chk("mix_done_valid", 32'(out_valid), 32'd0);
      chk("mix_done_count", 32'(out_count), 32'd0);

      // Ties and zeros
      send(NZ, 1'b0); send(PZ, 1'b1);
      chk("zero_min",     32'(out_min),     32'h20000);
      chk("zero_max",     32'(out_max),     32'h20000);
      chk("zero_min_idx", 32'(out_min_idx), 32'd0);
      chk("zero_max_idx", 32'(out_max_idx), 32'd0);
      step();
      send(N1, 1'b0); send(N1, 1'b1);
      chk("tie_min",     32'(out_min),     32'h2F800);
      chk("tie_max",     32'(out_max),     32'h2F800);
      chk("tie_min_idx", 32'(out_min_idx), 32'd0);
      chk("tie_max_idx", 32'(out_max_idx), 32'd0);
      step();

      // Backpressure
      out_ready = 1'b0;
      send(P2, 1'b1);
      in_valid = 1'b1; in_data = P1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_ready", 32'(in_ready),  32'd0);
         chk("bp_max",   32'(out_max),   32'h10000);
         chk("bp_min",   32'(out_min),   32'h10000);
         chk("bp_count", 32'(out_count), 32'd1);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_after_ready", 32'(in_ready),  32'd1);
      chk("bp_after_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_next_valid", 32'(out_valid), 32'd1);
      chk("bp_next_min",   32'(out_min),   32'h0F800);
      chk("bp_next_count", 32'(out_count), 32'd1);
      step();

      // Overflow on the IDX_W=2 instance
      send2(PZ, 1'b0); send2(PZ, 1'b0); send2(PZ, 1'b0); send2(PZ, 1'b0); send2(P2, 1'b1);
      chk("ovf_valid",   32'(out_valid2),    32'd1);
      chk("ovf_count",   32'(out_count2),    32'd4);
      chk("ovf_flag",    32'(out_overflow2), 32'd1);
      chk("ovf_max",     32'(out_max2),      32'h10000);
      chk("ovf_max_idx", 32'(out_max_idx2),  32'd3);
      chk("ovf_min_idx", 32'(out_min_idx2),  32'd0);
      step();
      chk("ovf_cleared", 32'(out_overflow2), 32'd0);

      // Asynchronous reset mid-stream
      send(P1, 1'b0); send(P2, 1'b0);
      chk("ar_pre_count", 32'(out_count), 32'd2);
      chk("ar_pre_max",   32'(out_max),   32'h10000);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_min",   32'(out_min),      32'd0);
      chk("ar_max",   32'(out_max),      32'd0);
      chk("ar_count", 32'(out_count),    32'd0);
      chk("ar_idx",   32'({out_min_idx, out_max_idx}), 32'd0);
      chk("ar_ovf",   32'(out_overflow), 32'd0);
      chk("ar_valid", 32'(out_valid),    32'd0);
      #1;
      reset = 1'b0;
      #1;
      chk("ar_ready", 32'(in_ready), 32'd1);
      step();
      send(N1, 1'b1);
      chk("ar_new_min",   32'(out_min),   32'h2F800);
      chk("ar_new_max",   32'(out_max),   32'h2F800);
      chk("ar_new_count", 32'(out_count), 32'd1);
      step();

      // Throughput: three 4-beat streams, in_valid and out_ready held high
      beat = 0; hs_cnt = 0; first_acc = -1; last_hs = -1;
      for (int c = 0; c < 40 && hs_cnt < 3; c++) begin
         if (beat < 12) begin
            in_valid = 1'b1;
            in_data  = tp_data[beat % 4];
            in_last  = ((beat % 4) == 3);
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            chk("tp_min",     32'(out_min),     32'h30000);
            chk("tp_max_idx", 32'(out_max_idx), 32'd2);
         end
         step();
         if (acc) begin
            if (first_acc < 0) first_acc = c;
            beat++;
         end
         if (hs) begin
            hs_cnt++;
            last_hs = c;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("tp_handshakes", 32'(hs_cnt), 32'd3);
      chk("tp_cycles", 32'(last_hs - first_acc + 1), 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
